// File: rtl/wb_iic_reg_slave.sv
// -----------------------------------------------------------------------------
// wb_iic_reg_slave
//
// Wishbone register front-end of the I2C bus controller. Decodes four byte
// registers, queues byte commands in a small FIFO and hands them one at a time
// to the downstream byte engine over a valid/ready channel. Engine responses
// are folded into sticky status bits that drive a level interrupt.
//
// Register map (adr_i[1:0]):
//   0 CSR  [7] E (rw), [6] IE (rw), [5] BUSY (ro), [4:0] read 0
//   1 DPR  write: staged data byte; read: byte of the last DONE response
//   2 CMDR write: push {dat_i[2:0], DPR}, clear status
//          read : [7] DON [6] NAK [5] AL [4] ERR [3] FULL [2:0] last code;
//                 a read also clears DON/NAK/AL/ERR
//   3 FSR  [3:0] FIFO entry count
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i        Wishbone cycle / strobe / write enable
//   adr_i, dat_i, dat_o       Wishbone address, write data, read data
//   ack_o                     single-cycle acknowledge (one per access)
//   irq_o                     level interrupt, IE & any status bit
//   cmd_valid_o, cmd_ready_i  command handshake to the byte engine
//   cmd_code_o, cmd_data_o    command code and data byte (head of FIFO)
//   rsp_valid_i               one-cycle response pulse from the engine
//   rsp_status_i, rsp_data_i  0=DONE 1=NAK 2=ARB_LOST 3=ERR, received byte
//
// Optional feature: define WB_IIC_CMD_TIMEOUT_EN to add a watchdog that
// aborts a command stuck in ISSUE or WAIT_RSP for TIMEOUT_CYCLES cycles
// (sets ERR, flushes the FIFO, returns to IDLE).
// -----------------------------------------------------------------------------
module wb_iic_reg_slave #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_code_o,
    output logic [7:0]            cmd_data_o,
    input  logic                  rsp_valid_i,
    input  logic [1:0]            rsp_status_i,
    input  logic [7:0]            rsp_data_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;

    if (DATA_WIDTH != 8 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES < 1 || ADDR_WIDTH < 2) begin : g_bad_params
        $error("wb_iic_reg_slave: unsupported parameter combination");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            ack_q, ack_d;
    logic            e_q, e_d;
    logic            ie_q, ie_d;
    logic [7:0]      dpr_q, dpr_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [2:0]      last_code_q, last_code_d;
    logic            don_q, don_d;
    logic            nak_q, nak_d;
    logic            al_q, al_d;
    logic            err_q, err_d;
    logic            irq_q, irq_d;
    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [10:0]     fifo_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Bus decode: side effects only in the cycle ack_o is high
    // ------------------------------------------------------------------
    logic       access, bus_wr, bus_rd;
    logic [1:0] reg_sel;
    logic       csr_wr, dpr_wr, cmdr_wr, cmdr_rd;

    assign access  = ack_q & cyc_i & stb_i;
    assign bus_wr  = access & we_i;
    assign bus_rd  = access & ~we_i;
    assign reg_sel = adr_i[1:0];
    assign csr_wr  = bus_wr & (reg_sel == 2'd0);
    assign dpr_wr  = bus_wr & (reg_sel == 2'd1);
    assign cmdr_wr = bus_wr & (reg_sel == 2'd2);
    assign cmdr_rd = bus_rd & (reg_sel == 2'd2);

    logic fifo_full, push, push_drop, e_fall, handshake, rsp_take;
    logic timeout_hit, flush, busy;

    // Full is judged on the registered count, before any same-cycle pop.
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign push      = cmdr_wr & e_q & ~fifo_full;
    assign push_drop = cmdr_wr & ~push;
    assign e_fall    = csr_wr & e_q & ~dat_i[7];
    assign handshake = (state_q == ST_ISSUE) & cmd_ready_i;
    assign rsp_take  = (state_q == ST_WAIT_RSP) & rsp_valid_i;
    assign flush     = e_fall | timeout_hit;
    assign busy      = (state_q != ST_IDLE) | (count_q != '0);

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (e_q && count_q != '0) state_d = ST_ISSUE;
            ST_ISSUE:    if (cmd_ready_i)          state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: if (rsp_valid_i)          state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

`ifdef WB_IIC_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;

    // A handshake or response on the last allowed cycle still counts as progress.
    assign timeout_hit = (state_q != ST_IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1))
                         && !handshake && !rsp_take;

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (state_q == ST_IDLE || state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FIFO pointers and count
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(handshake);
        count_d  = count_q + CW'(push) - CW'(handshake);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Storage is not reset; the outputs are gated by cmd_valid_o.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= {dat_i[2:0], dpr_q};
    end

    // ------------------------------------------------------------------
    // Registers and status
    // ------------------------------------------------------------------
    always_comb begin
        ack_d       = cyc_i & stb_i & ~ack_q;
        e_d         = csr_wr ? dat_i[7] : e_q;
        ie_d        = csr_wr ? dat_i[6] : ie_q;
        dpr_d       = dpr_wr ? dat_i[7:0] : dpr_q;
        last_code_d = push ? dat_i[2:0] : last_code_q;
        rdata_d     = rdata_q;
        don_d       = don_q;
        nak_d       = nak_q;
        al_d        = al_q;
        err_d       = err_q;

        if (cmdr_wr || cmdr_rd) begin
            don_d = 1'b0;
            nak_d = 1'b0;
            al_d  = 1'b0;
            err_d = 1'b0;
        end
        if (push_drop || timeout_hit) err_d = 1'b1;

        // Response is applied last so it overrides a same-cycle clear.
        if (rsp_take) begin
            case (rsp_status_i)
                2'd0: begin
                    don_d   = 1'b1;
                    rdata_d = rsp_data_i;
                end
                2'd1:    nak_d = 1'b1;
                2'd2:    al_d  = 1'b1;
                default: err_d = 1'b1;
            endcase
        end

        irq_d = ie_d & (don_d | nak_d | al_d | err_d);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q       <= 1'b0;
            e_q         <= 1'b0;
            ie_q        <= 1'b0;
            dpr_q       <= '0;
            rdata_q     <= '0;
            last_code_q <= '0;
            don_q       <= 1'b0;
            nak_q       <= 1'b0;
            al_q        <= 1'b0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            ack_q       <= ack_d;
            e_q         <= e_d;
            ie_q        <= ie_d;
            dpr_q       <= dpr_d;
            rdata_q     <= rdata_d;
            last_code_q <= last_code_d;
            don_q       <= don_d;
            nak_q       <= nak_d;
            al_q        <= al_d;
            err_q       <= err_d;
            irq_q       <= irq_d;
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [7:0]  rd_mux;
    logic [10:0] head;

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            2'd0: rd_mux = {e_q, ie_q, busy, 5'b0};
            2'd1: rd_mux = rdata_q;
            2'd2: rd_mux = {don_q, nak_q, al_q, err_q, fifo_full, last_code_q};
            2'd3: rd_mux = {4'b0, 4'(count_q)};
            default: rd_mux = 8'h00;
        endcase
    end

    assign head        = fifo_mem[rd_ptr_q];
    assign ack_o       = ack_q;
    assign dat_o       = ack_q ? rd_mux : '0;
    assign irq_o       = irq_q;
    assign cmd_valid_o = (state_q == ST_ISSUE);
    assign cmd_code_o  = cmd_valid_o ? head[10:8] : 3'd0;
    assign cmd_data_o  = cmd_valid_o ? head[7:0]  : 8'd0;

endmodule
